octal_decoder_stream: RTL
=========================

Name: octal_decoder_stream

Overview:
- Binary-to-octal (3-to-8 one-hot) decoder with a valid/ready stream interface on both sides.
- Accepts a 3-bit code plus an enable bit, buffers it in a 2-entry FIFO and presents a registered one-hot D0..D7 word downstream.
- Keeps a saturating count of delivered words.
- Sits on the receive side of links driven by the octal-to-binary encoder, and restores the original one-hot lines.

Parameters:
- CNT_W, 8, width of the delivered-word counter.
- DEPTH, 2, FIFO entries. Only value 2 is supported; any other value is a synthesis error.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has a code
- in_ready  output  1  block can accept a code this cycle
- in_code  input  3  binary code {A,B,C}, A = MSB
- in_en  input  1  decode enable captured with the code; 0 produces an all-zero one-hot word
- out_valid  output  1  out_onehot/out_code hold a word
- out_ready  input  1  downstream accepts the word
- out_onehot  output  8  bit i = Di; exactly one bit set when enabled
- out_code  output  3  code of the word being presented
- out_dis  output  1  1 when the presented word was captured with in_en=0
- word_cnt  output  CNT_W  number of delivered words, saturating

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO is emptied; rd_ptr, wr_ptr and occupancy go to 0.
  - in_ready=1, out_valid=0, out_onehot=0, out_code=0, out_dis=0, word_cnt=0.
  - Reset mid-transfer discards any buffered words. No handshake completes in a cycle where rst=1.
- Push:
  - Occurs when in_valid & in_ready at the edge.
  - The entry stores {in_code, in_en}; in_code is ignored when in_valid=0.
- Pop:
  - Occurs when out_valid & out_ready at the edge.
- in_ready = (occupancy < 2). It is a register-derived flag, with no combinational path from out_ready.
- out_valid = (occupancy > 0).
- Outputs come from the FIFO head:
  - out_onehot = head.en ? (8'b1 << head.code) : 8'h00.
  - out_code = head.code.
  - out_dis = ~head.en.
  - When out_valid=0, out_onehot=0, out_code=0 and out_dis=0.
- Latency: a code pushed at edge N is visible on out_* after edge N, provided the FIFO was empty. Sustained throughput is 1 word per cycle while out_ready=1.
- Occupancy update:
  - push only: +1
  - pop only: -1
  - push and pop in the same cycle: unchanged, with both pointers advancing
- Full (occupancy=2): in_ready=0, so no push is possible even if out_ready=1 that cycle. After the pop, in_ready=1 on the next cycle.
- Empty with a push in the same cycle: out_valid stays 0 that cycle; there is no bypass path.
- Pointers are 1 bit and wrap 1→0.
- out_valid=1 & out_ready=0: head is held and out_* stay stable until the pop.
- word_cnt increments by 1 on each pop and saturates at 2^CNT_W−1. No wrap.
- Disabled words (in_en=0) are delivered and counted like any other word.

Test Plan:
- Reset then push codes 0..7 with en=1 and out_ready=1 held: out_onehot sequence 01,02,04,08,10,20,40,80, each one cycle after its push; word_cnt=8.
- out_ready=0, push 3 then 5: in_ready drops to 0 after the 2nd push, and a 3rd push attempt (code 6) is not accepted. Raise out_ready: outputs 08 then 20, then in_ready=1; push 6 → 40.
- Push code 4 with en=0: out_onehot=00, out_code=4, out_dis=1, word_cnt increments.
- Occupancy 1, simultaneous push(2) and pop: occupancy stays 1 and the next word is 04. No word is lost or duplicated over 100 random valid/ready cycles, checked by a scoreboard.
- CNT_W=3, deliver 10 words: word_cnt reaches 7 and holds.
- Assert rst with 2 words buffered: next cycle out_valid=0, out_onehot=00, word_cnt=0, in_ready=1. The buffered words never appear.

Source files
------------

// File: rtl/octal_decoder_stream_if.sv
// Valid/ready stream bundle for the octal decoder: code+enable in, one-hot word out.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface octal_decoder_stream_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_code;
   logic       in_en;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_onehot;
   logic [2:0] out_code;
   logic       out_dis;

   modport master (
      output in_valid, in_code, in_en, out_ready,
      input  in_ready, out_valid, out_onehot, out_code, out_dis
   );

   modport slave (
      input  in_valid, in_code, in_en, out_ready,
      output in_ready, out_valid, out_onehot, out_code, out_dis
   );
endinterface

// File: rtl/octal_decoder_stream.sv
// 3-to-8 one-hot decoder behind a 2-entry valid/ready FIFO, with a saturating
// count of delivered words.
module octal_decoder_stream #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   octal_decoder_stream_if.slave s,
   output logic [CNT_W-1:0]      word_cnt
);

   if (DEPTH != 2) begin : g_depth_check
      $error("octal_decoder_stream: only DEPTH=2 is supported");
   end

   typedef struct packed {
      logic [2:0] code;
      logic       en;
   } entry_t;

   function automatic logic [7:0] decode(input entry_t e);
      return e.en ? (8'b1 << e.code) : 8'h00;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   entry_t     mem [0:1];
   entry_t     head;
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] occ;
   logic       push;
   logic       pop;

   // Both flags come straight from the occupancy register, so out_ready
   // never reaches in_ready combinationally.
   assign s.in_ready  = (occ != 2'd2);
   assign s.out_valid = (occ != 2'd0);
   assign push        = s.in_valid & s.in_ready;
   assign pop         = s.out_valid & s.out_ready;
   assign head        = mem[rd_ptr];

   assign s.out_onehot = s.out_valid ? decode(head) : 8'h00;
   assign s.out_code   = s.out_valid ? head.code : 3'd0;
   assign s.out_dis    = s.out_valid & ~head.en;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         occ      <= 2'd0;
         word_cnt <= '0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) begin
            rd_ptr   <= ~rd_ptr;
            word_cnt <= sat_inc(word_cnt);
         end
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !rst) mem[wr_ptr] <= '{code: s.in_code, en: s.in_en};
   end

endmodule
